// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt controller.
//   IRQ_W         width of the scan index / served line id
//   MCAUSE_BASE   mcause value for line 0 (interrupt bit set, cause 16)
//   ST_*          FSM state encodings (kept as plain constants for legacy code)
//   irq_state_t   enum view of the same encodings
//   idx_next      wrapping increment of a scan index over the implemented lines
package irq_pkg;

  localparam int unsigned IRQ_W       = 5;
  localparam logic [31:0] MCAUSE_BASE = 32'h8000_0010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    FIN  = ST_FIN
  } irq_state_t;

  // Returns cur+1, wrapping to 0 after the last implemented line (num-1).
  function automatic logic [IRQ_W-1:0] idx_next(input logic [IRQ_W-1:0] cur,
                                                input int unsigned    num);
    if (32'(cur) >= num - 32'd1) begin
      return '0;
    end
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/irq_ctrl.sv
// irq_ctrl: round-robin interrupt controller.
// Scans level requests one line per cycle, masked by mie; on a hit it raises
// int_o with the matching mcause, waits for the core's handler-done pulse,
// then returns a one-cycle one-hot finish pulse to the served peripheral and
// resumes scanning at the line after the one just served.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   int_req_i  level requests, bit n held until int_fin_o[n]
//   mie_i      per-line enable mask
//   int_rst_i  one-cycle handler-finished pulse from the core
//   int_o      interrupt request to the core
//   mcause_o   cause of the line currently / last served
//   int_fin_o  one-hot one-cycle finish pulse to the served line
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned IRQ_NUM = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] int_req_i,
  input  logic [31:0] mie_i,
  input  logic        int_rst_i,
  output logic        int_o,
  output logic [31:0] mcause_o,
  output logic [31:0] int_fin_o
);

  // Finish bits of unimplemented lines are forced to 0.
  localparam logic [31:0] LINE_MASK =
    (IRQ_NUM >= 32) ? '1 : ((32'd1 << IRQ_NUM) - 32'd1);

  logic [1:0]       state;
  logic [IRQ_W-1:0] idx;
  logic [IRQ_W-1:0] irq_id;
  logic [31:0]      mcause;
  logic             hit;

  // idx never exceeds IRQ_NUM-1, so lines above IRQ_NUM are never looked at.
  assign hit = int_req_i[idx] & mie_i[idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      idx    <= '0;
      irq_id <= '0;
      mcause <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            irq_id <= idx;
            mcause <= MCAUSE_BASE + 32'(idx);
            state  <= ST_BUSY;
          end else begin
            idx <= idx_next(idx, IRQ_NUM);
          end
        end
        ST_BUSY: begin
          if (int_rst_i) begin
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          // Restart after the served line so a persistent requester cannot starve others.
          idx   <= idx_next(irq_id, IRQ_NUM);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign int_o     = (state == ST_BUSY);
  assign int_fin_o = (state == ST_FIN) ? ((32'd1 << irq_id) & LINE_MASK) : '0;
  assign mcause_o  = mcause;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (IRQ_NUM = 32).
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_rst;
  logic [31:0] req;
  logic [31:0] mie;
  logic        int_o;
  logic [31:0] mcause;
  logic [31:0] fin;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.IRQ_NUM(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .int_req_i (req),
    .mie_i     (mie),
    .int_rst_i (int_rst),
    .int_o     (int_o),
    .mcause_o  (mcause),
    .int_fin_o (fin)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_int(input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (int_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, int_o}, 32'd1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pulse int_rst while BUSY on 'line'; check the FIN cycle and IDLE re-entry.
  // When drop is set the peripheral clears its request on the edge ending FIN.
  task automatic finish_irq(input int unsigned line, input bit drop);
    int_rst = 1'b1;
    tick();
    int_rst = 1'b0;
    chk("fin_pulse", fin, 32'd1 << line);
    chk("fin_int_low", {31'b0, int_o}, 32'd0);
    chk("fin_mcause", mcause, 32'h8000_0010 + line);
    tick();
    if (drop) req[line] = 1'b0;
    chk("fin_one_cycle", fin, 32'd0);
    chk("idle_idx", {27'b0, dut.idx}, (line + 1) % 32);
  endtask

  initial begin
    rst     = 1'b1;
    int_rst = 1'b0;
    req     = '0;
    mie     = '0;

    // Reset values
    tick();
    chk("rst_int", {31'b0, int_o}, 32'd0);
    chk("rst_fin", fin, 32'd0);
    chk("rst_mcause", mcause, 32'd0);
    chk("rst_idx", {27'b0, dut.idx}, 32'd0);
    tick();
    rst = 1'b0;

    // Idle scan with no requests
    for (int i = 0; i < 100; i++) begin
      chk("idle_idx_scan", {27'b0, dut.idx}, i % 32);
      chk("idle_int", {31'b0, int_o}, 32'd0);
      chk("idle_fin", fin, 32'd0);
      chk("idle_mcause", mcause, 32'd0);
      tick();
    end

    // Single request on line 0 (idx is 4 here)
    mie = 32'h1;
    req = 32'h1;
    wait_int(33, "l0_int");
    chk("l0_mcause", mcause, 32'h8000_0010);
    chk("l0_fin_busy", fin, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l0_busy_hold", {31'b0, int_o}, 32'd1);
    end
    finish_irq(0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("l0_no_reserve", {31'b0, int_o}, 32'd0);
      chk("l0_no_refin", fin, 32'd0);
    end

    // Round robin between lines 0 and 2, requests held
    reset_dut();
    mie = '1;
    req = 32'h0000_0005;
    tick();
    chk("rr_latency", {31'b0, int_o}, 32'd1);
    chk("rr_mcause0", mcause, 32'h8000_0010);
    tick();
    finish_irq(0, 1'b0);
    wait_int(33, "rr_int2");
    chk("rr_mcause2", mcause, 32'h8000_0012);
    finish_irq(2, 1'b0);
    wait_int(33, "rr_int0b");
    chk("rr_mcause0b", mcause, 32'h8000_0010);
    finish_irq(0, 1'b0);
    req = '0;

    // Masked line 3 stays pending until enabled
    reset_dut();
    mie = 32'hFFFF_FFF7;
    req = 32'h0000_0008;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("mask_int", {31'b0, int_o}, 32'd0);
    end
    mie = '1;
    wait_int(33, "unmask_int");
    chk("unmask_mcause", mcause, 32'h8000_0013);
    finish_irq(3, 1'b1);

    // Reset in the middle of serving line 7
    req = 32'h0000_0080;
    wait_int(40, "l7_int");
    chk("l7_mcause", mcause, 32'h8000_0017);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_int", {31'b0, int_o}, 32'd0);
    chk("mid_rst_fin", fin, 32'd0);
    chk("mid_rst_mcause", mcause, 32'd0);
    chk("mid_rst_idx", {27'b0, dut.idx}, 32'd0);
    tick();
    chk("mid_rst_fin2", fin, 32'd0);
    tick();
    rst = 1'b0;
    wait_int(40, "l7_reserve");
    chk("l7_mcause2", mcause, 32'h8000_0017);
    finish_irq(7, 1'b1);

    // Request and mask drop while BUSY on line 4
    req = 32'h0000_0010;
    wait_int(40, "l4_int");
    chk("l4_mcause", mcause, 32'h8000_0014);
    req = '0;
    mie = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("l4_hold_int", {31'b0, int_o}, 32'd1);
      chk("l4_hold_fin", fin, 32'd0);
    end
    finish_irq(4, 1'b0);
    mie = '1;

    // int_rst in IDLE is ignored
    int_rst = 1'b1;
    tick();
    int_rst = 1'b0;
    chk("idle_rst_int", {31'b0, int_o}, 32'd0);
    chk("idle_rst_fin", fin, 32'd0);
    tick();
    chk("idle_rst_fin2", fin, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller between the peripheral controllers and the core's CSR/trap logic. It collects level interrupt requests from peripherals such as the switch and keyboard controllers, masks them with the `mie` CSR value, and selects one source round-robin. It raises a single interrupt to the core with the matching `mcause`. When the core reports the handler complete, it returns a one-cycle finish pulse to the served source so that source clears its request.

## Interface
Parameters:
- `IRQ_NUM`, default 32: number of implemented request lines, 1..32. Lines at and above `IRQ_NUM` are ignored, and their `int_fin_o` bits are tied to 0.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `int_req_i`  in  32  level requests from peripherals; bit n is held high until `int_fin_o[n]`
- `mie_i`  in  32  interrupt enable mask from CSR unit; bit n = 1 enables line n
- `int_rst_i`  in  1  one-cycle pulse from core: handler finished (mret)
- `int_o`  out  1  interrupt request to core
- `mcause_o`  out  32  cause for the currently served line
- `int_fin_o`  out  32  one-hot, one-cycle finish pulse to the served peripheral

## Operation
- Registered 5-bit scan index `idx`, reset 0. Index wraps at `IRQ_NUM-1` → 0.
- `hit` = `int_req_i[idx] & mie_i[idx]`. Combinational, current index only.
- FSM states: IDLE, BUSY, FIN. Reset state is IDLE.
  - IDLE: if `hit`, latch `irq_id <= idx` and go to BUSY. Otherwise advance `idx` and stay in IDLE.
  - BUSY: `int_o` = 1. `idx` is frozen. Go to FIN on `int_rst_i`.
  - FIN: `int_fin_o` = 1 << `irq_id`, for exactly one cycle. Set `idx <= irq_id + 1` (wrapped), then go to IDLE.
- `mcause_o` = 32'h8000_0010 + `irq_id`, registered when BUSY is entered. It holds through BUSY and FIN and keeps its last value in IDLE.
- `int_o` and `int_fin_o` are decoded from registered state only. They never depend combinationally on inputs.
- Round-robin: after serving line k, the scan restarts at k+1. A continuously requesting line cannot starve the others.
- Masked lines (`mie_i[n]` = 0) are never selected, and their requests stay pending.
- Boundary behaviour:
  - A request that drops while BUSY is still completed: BUSY waits for `int_rst_i`, and the FIN pulse is still issued.
  - A change to `mie_i` during BUSY or FIN has no effect on the current service.
  - `int_rst_i` in IDLE or FIN is ignored.
  - A new request arriving during BUSY or FIN stays pending and is picked up by the scan after return to IDLE.
  - Reset mid-service: all state, `idx` and outputs clear immediately. No FIN pulse is issued, so the peripheral keeps its request and it is re-served after reset.

## Timing
- Reset values: `int_o` = 0, `mcause_o` = 0, `int_fin_o` = 0, `idx` = 0, state = IDLE.
- Latency, `hit` at edge t → `int_o` = 1 from cycle t+1.
- Worst-case detect latency from request to `int_o`: `IRQ_NUM` cycles of scan + 1.
- `int_rst_i` sampled at edge t → `int_fin_o` high in cycle t+1 only, and `int_o` low from t+1.
- IDLE re-entry at t+2 with `idx` = `irq_id`+1. The peripheral clears its request on the edge ending the FIN cycle, so the same pending request is never taken twice.
- Back-to-back services: minimum 3 cycles per interrupt plus handler time.

## Structure
- Shared package `irq_pkg`:
  - state enum `irq_state_t` {IDLE, BUSY, FIN}
  - `MCAUSE_BASE` = 32'h8000_0010
  - `IRQ_W` = 5
- Single module. No sub-module is needed; the scan counter and FSM fit in one `always_ff` pair plus output decode.

## Test plan
- Reset, then no requests → `int_o`, `int_fin_o` and `mcause_o` stay 0 for 100 cycles, and `idx` cycles through 0..31.
- `int_req_i[0]` = 1 with `mie_i` = 32'h1 → `int_o` = 1 and `mcause_o` = 32'h8000_0010. `int_rst_i` pulse → next cycle `int_fin_o` = 32'h1, then `int_o` = 0. The request is dropped by the bench on the FIN edge, and no second service follows.
- `int_req_i` = 32'h0000_0005 held, `mie_i` = all ones → services alternate line 0, line 2, line 0, with `mcause_o` values …10, …12, …10.
- `int_req_i[3]` = 1, `mie_i[3]` = 0 for 200 cycles → `int_o` stays 0. Set `mie_i[3]` = 1 → `int_o` within 33 cycles with `mcause_o` = 32'h8000_0013.
- Assert `rst_i` while BUSY on line 7 → `int_o` = 0 immediately and no FIN pulse. After release, line 7 (still requesting) is served again.
- Drop `int_req_i[4]` while BUSY on line 4 → `int_o` stays 1 until `int_rst_i`, and `int_fin_o` = 32'h10 for exactly one cycle.
